serial_pair_serializer: RTL and testbench



---
 rtl/serial_pkg.sv | 19 +
 rtl/serial_shift_reg.sv | 55 +++++
 rtl/serial_pair_serializer.sv | 122 ++++++++++++
 tb/tb_serial_pair_serializer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// ----------------------------------------------------------------------------
// serial_pkg
// Types and helpers shared by the serial pair serializer and its shift register.
//   state_t   : serializer FSM state (st_idle, st_shift)
//   cnt_width : width of the bit counter for a W-bit word, never less than 1
// ----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic {
        st_idle  = 1'b0,
        st_shift = 1'b1
    } state_t;

    // A 1-bit word still needs a 1-bit counter so the port/reg widths stay legal.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage : serial_pkg

// File: rtl/serial_shift_reg.sv
// ----------------------------------------------------------------------------
// serial_shift_reg
// W-bit parallel-load shift register that presents one head bit per cycle.
// Parameters:
//   W         : word width (>= 1)
//   MSB_FIRST : 1 = head is bit W-1 and data moves toward the MSB,
//               0 = head is bit 0 and data moves toward the LSB
// Ports:
//   clk   in  : rising-edge clock
//   rst   in  : asynchronous active-low reset, clears the register
//   load  in  : capture d (wins over shift)
//   shift in  : advance one position, vacated bit filled with 0
//   d     in  : parallel word
//   q_bit out : current head bit
// ----------------------------------------------------------------------------
module serial_shift_reg #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         q_bit
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift) begin
            // Shift operators rather than part-selects keep W = 1 legal.
            sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
        end
    end

    // NOTE: state registers use non-blocking assignments only, and this data
    // register is reset too: an aborted frame must not leave stale bits behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_bit = MSB_FIRST ? sr_q[W-1] : sr_q[0];

endmodule : serial_shift_reg

// File: rtl/serial_pair_serializer.sv
// ----------------------------------------------------------------------------
// serial_pair_serializer
// Turns a pair of W-bit words into two lock-stepped serial streams a/b, one
// bit per cycle, with first/last frame markers, downstream stall and
// back-to-back reload on the last bit.
// Parameters:
//   W         : word width (>= 1)
//   MSB_FIRST : 1 = bit W-1 sent first, 0 = bit 0 sent first
// Ports:
//   clk       in  : rising-edge clock
//   rst       in  : asynchronous active-low reset
//   in_valid  in  : source presents a word pair
//   in_ready  out : pair accepted on this edge when in_valid is high
//   a_word    in  : operand A
//   b_word    in  : operand B
//   hold      in  : downstream stall, freezes shifting
//   a, b      out : serial bits (0 when out_valid is low)
//   out_valid out : a/b carry a real bit this cycle
//   out_first out : current bit is the first of its frame
//   out_last  out : current bit is the last of its frame
// ----------------------------------------------------------------------------
module serial_pair_serializer
    import serial_pkg::*;
#(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_word,
    input  logic [W-1:0] b_word,
    input  logic         hold,
    output logic         a,
    output logic         b,
    output logic         out_valid,
    output logic         out_first,
    output logic         out_last
);

    localparam int            CW       = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic cnt_is_last;
    logic xfer;
    logic shift_en;
    logic a_head;
    logic b_head;

    assign cnt_is_last = (cnt_q == CNT_LAST);
    assign out_valid   = (state_q == st_shift) && !hold;

    // Reset is folded into in_ready combinationally so the source sees "not
    // ready" for the whole time rst is low, not just after the next edge.
    assign in_ready = rst && ((state_q == st_idle) ||
                              ((state_q == st_shift) && cnt_is_last && !hold));

    assign xfer     = in_valid && in_ready;
    // A reload on the last bit replaces the shift; load has priority anyway.
    assign shift_en = out_valid && !xfer;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            state_d = st_shift;
            cnt_d   = '0;
        end else if (out_valid) begin
            if (cnt_is_last) begin
                state_d = st_idle;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= st_idle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    serial_shift_reg #(
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (xfer),
        .shift (shift_en),
        .d     (a_word),
        .q_bit (a_head)
    );

    serial_shift_reg #(
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (xfer),
        .shift (shift_en),
        .d     (b_word),
        .q_bit (b_head)
    );

    // All serial outputs are gated so a stalled or idle cycle shows clean zeros.
    assign a         = out_valid && a_head;
    assign b         = out_valid && b_head;
    assign out_first = out_valid && (cnt_q == '0);
    assign out_last  = out_valid && cnt_is_last;

endmodule : serial_pair_serializer

// File: tb/tb_serial_pair_serializer.sv
// ----------------------------------------------------------------------------
// tb_serial_pair_serializer
// Four serializer instances: W=4 MSB-first (0), W=4 LSB-first (1), W=1 (2),
// W=8 MSB-first (3). Word pairs are queued per instance; when the handshake
// accepts a pair, its expected serial bits {a,b,first,last} are pushed to a
// scoreboard and popped as the DUT reports out_valid.
// ----------------------------------------------------------------------------
module tb_serial_pair_serializer;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] iv, hd, rdy, ao, bo, ov, of, ol;
    logic [7:0] aw [4];
    logic [7:0] bw [4];

    pair_t      pend [4][$];
    logic [3:0] sbq  [4][$];

    int         vectors     = 0;
    int         miscompares = 0;
    int         vcnt [4];
    logic [3:0] rdy_s, ov_s;

    always #5 clk = ~clk;

    serial_pair_serializer #(.W(4), .MSB_FIRST(1'b1)) u_w4_msb (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
        .a_word(aw[0][3:0]), .b_word(bw[0][3:0]), .hold(hd[0]),
        .a(ao[0]), .b(bo[0]), .out_valid(ov[0]), .out_first(of[0]), .out_last(ol[0]));

    serial_pair_serializer #(.W(4), .MSB_FIRST(1'b0)) u_w4_lsb (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
        .a_word(aw[1][3:0]), .b_word(bw[1][3:0]), .hold(hd[1]),
        .a(ao[1]), .b(bo[1]), .out_valid(ov[1]), .out_first(of[1]), .out_last(ol[1]));

    serial_pair_serializer #(.W(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]),
        .a_word(aw[2][0:0]), .b_word(bw[2][0:0]), .hold(hd[2]),
        .a(ao[2]), .b(bo[2]), .out_valid(ov[2]), .out_first(of[2]), .out_last(ol[2]));

    serial_pair_serializer #(.W(8), .MSB_FIRST(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(rdy[3]),
        .a_word(aw[3]), .b_word(bw[3]), .hold(hd[3]),
        .a(ao[3]), .b(bo[3]), .out_valid(ov[3]), .out_first(of[3]), .out_last(ol[3]));

    function automatic int wk(input int k);
        case (k)
            2:       return 1;
            3:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic bit msbk(input int k);
        return (k != 1);
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[inst %0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // Reference serial order: bit i of the frame comes from position W-1-i
    // (MSB first) or i (LSB first).
    task automatic push_exp(input int k, input pair_t p);
        int w;
        w = wk(k);
        for (int i = 0; i < w; i++) begin
            int   pos;
            logic fst, lst;
            pos = msbk(k) ? (w - 1 - i) : i;
            fst = (i == 0);
            lst = (i == w - 1);
            sbq[k].push_back({p.a[pos], p.b[pos], fst, lst});
        end
    endtask

    // One cycle: drive from the pending queues at the falling edge, settle,
    // check outputs against the scoreboard, record accepted pairs, advance.
    task automatic step();
        for (int k = 0; k < 4; k++) begin
            if (pend[k].size() > 0 && rst) begin
                iv[k] = 1'b1;
                aw[k] = pend[k][0].a;
                bw[k] = pend[k][0].b;
            end else begin
                iv[k] = 1'b0;
                aw[k] = 8'($urandom);
                bw[k] = 8'($urandom);
            end
        end
        #1;
        rdy_s = rdy;
        ov_s  = ov;
        for (int k = 0; k < 4; k++) begin
            if (ov[k]) begin
                vcnt[k]++;
                if (sbq[k].size() == 0) begin
                    check("unexpected_bit", k, 32'(ov[k]), 32'd0);
                end else begin
                    logic [3:0] e;
                    e = sbq[k].pop_front();
                    check("serial_bits", k, {28'd0, ao[k], bo[k], of[k], ol[k]}, {28'd0, e});
                end
            end else begin
                check("gated_zero", k, {28'd0, ao[k], bo[k], of[k], ol[k]}, 32'd0);
            end
            if (iv[k] && rdy[k]) begin
                pair_t p;
                p = pend[k].pop_front();
                push_exp(k, p);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while ((sbq[k].size() > 0 || pend[k].size() > 0) && n < 200) begin
            step();
            n++;
        end
        check("drain_timeout", k, sbq[k].size() + pend[k].size(), 32'd0);
    endtask

    task automatic wait_ov(input int k);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ov_s[k] && n < 50);
        check("wait_ov_timeout", k, 32'(ov_s[k]), 32'd1);
    endtask

    task automatic wait_bits(input int k, input int target);
        int n;
        n = 0;
        while (vcnt[k] < target && n < 100) begin
            step();
            n++;
        end
        check("wait_bits_timeout", k, 32'(vcnt[k] >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst = 1'b0;
        iv  = '0;
        hd  = '0;
        for (int k = 0; k < 4; k++) begin
            aw[k]   = '0;
            bw[k]   = '0;
            vcnt[k] = 0;
        end

        // Reset state
        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("reset_outputs", k, {27'd0, ao[k], bo[k], ov[k], of[k], ol[k]}, 32'd0);
            check("reset_ready", k, 32'(rdy[k]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_release", 0, {28'd0, rdy}, 32'hF);
        @(negedge clk);

        // Basic MSB-first frame on W=4 and LSB-first frame in parallel
        pend[0].push_back('{a: 8'hA, b: 8'h9});
        pend[1].push_back('{a: 8'h1, b: 8'h6});
        wait_ov(0);
        for (int j = 1; j < 4; j++) begin
            step();
            check("basic_gapless", 0, 32'(ov_s[0]), 32'd1);
        end
        step();
        check("basic_ends", 0, 32'(ov_s[0]), 32'd0);
        drain(0);
        drain(1);

        // Back-to-back frames: 8 valid cycles, in_ready on last-bit cycles
        pend[0].push_back('{a: 8'hF, b: 8'h0});
        pend[0].push_back('{a: 8'h3, b: 8'hC});
        wait_ov(0);
        check("b2b_ready", 0, 32'(rdy_s[0]), 32'd0);
        for (int j = 1; j < 8; j++) begin
            step();
            check("b2b_valid", 0, 32'(ov_s[0]), 32'd1);
            check("b2b_ready", 0, 32'(rdy_s[0]), 32'((j == 3) || (j == 7)));
        end
        step();
        check("b2b_idle_after", 0, 32'(ov_s[0]), 32'd0);
        check("b2b_idle_ready", 0, 32'(rdy_s[0]), 32'd1);

        // Hold for 3 cycles after bit 2
        base = vcnt[0];
        pend[0].push_back('{a: 8'hA, b: 8'h5});
        wait_bits(0, base + 2);
        hd[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            check("hold_quiet", 0, 32'(ov_s[0]), 32'd0);
        end
        hd[0] = 1'b0;
        step();
        check("hold_resume", 0, 32'(ov_s[0]), 32'd1);
        drain(0);

        // Hold on the last bit: not ready, last bit repeats, then reload
        base = vcnt[0];
        pend[0].push_back('{a: 8'hC, b: 8'h3});
        pend[0].push_back('{a: 8'h6, b: 8'h9});
        wait_bits(0, base + 3);
        hd[0] = 1'b1;
        step();
        check("hold_last_ready", 0, 32'(rdy_s[0]), 32'd0);
        check("hold_last_quiet", 0, 32'(ov_s[0]), 32'd0);
        hd[0] = 1'b0;
        step();
        check("last_repeat_valid", 0, 32'(ov_s[0]), 32'd1);
        check("last_repeat_ready", 0, 32'(rdy_s[0]), 32'd1);
        drain(0);

        // W=1 streaming: first and last on every bit, no gap
        pend[2].push_back('{a: 8'h1, b: 8'h0});
        pend[2].push_back('{a: 8'h0, b: 8'h1});
        wait_ov(2);
        step();
        check("w1_stream", 2, 32'(ov_s[2]), 32'd1);
        drain(2);

        // Asynchronous reset mid-frame on W=8, then a fresh full frame
        base = vcnt[3];
        pend[3].push_back('{a: 8'hFF, b: 8'h00});
        wait_bits(3, base + 3);
        rst = 1'b0;
        #1;
        check("abort_outputs", 3, {27'd0, ao[3], bo[3], ov[3], of[3], ol[3]}, 32'd0);
        check("abort_ready", 3, 32'(rdy[3]), 32'd0);
        sbq[3].delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_abort", 3, 32'(rdy[3]), 32'd1);
        @(negedge clk);
        pend[3].push_back('{a: 8'h01, b: 8'h02});
        drain(3);

        // Nothing left outstanding anywhere
        for (int k = 0; k < 4; k++) begin
            step();
            check("scoreboard_empty", k, sbq[k].size(), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_pair_serializer
